// File: rtl/vppm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vppm_pkg
// Description : Shared VPPM definitions: counter width, receiver state
//               encoding and the slot-length rule used by TX and RX.
// Revision    : 1.0 - initial release
// ============================================================================
package vppm_pkg;

    localparam int CNT_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    // One extra bit so the maximum N cannot wrap the slot length.
    function automatic logic [CNT_W:0] slot_len(input logic [CNT_W-1:0] n);
        return {1'b0, n} + {{(CNT_W-1){1'b0}}, 2'd2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchroniser for an asynchronous input plus a
//               delayed copy for rising-edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/vppm_slot_demod.sv
`default_nettype none
// ============================================================================
// Module      : vppm_slot_demod
// Description : VPPM slot demodulator: locks a slot counter on the first
//               rising edge, integrates each half-slot, emits one bit/slot.
// Revision    : 1.0 - initial release
// ============================================================================
module vppm_slot_demod
    import vppm_pkg::*;
#(
    parameter int LOSS_SLOTS = 4
) (
    input  logic             clk,
    input  logic             sclear,
    input  logic             en,
    input  logic             din,
    input  logic [CNT_W-1:0] N,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             bit_out,
    output logic             erasure,
    output logic [CNT_W-1:0] hi_cnt,
    output logic             locked,
    output logic             overrun
);

    localparam int                ERR_W      = $clog2(LOSS_SLOTS + 1);
    localparam logic [ERR_W-1:0]  c_LOSS_MAX = ERR_W'(LOSS_SLOTS);

    logic             din_s;
    logic             rise;

    state_e           state_q;
    logic [CNT_W:0]   pos_q;
    logic [CNT_W:0]   l_q;
    logic [CNT_W:0]   h_q;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;
    logic [ERR_W-1:0] err_q;
    logic             valid_q;
    logic             bit_q;
    logic             era_q;
    logic [CNT_W-1:0] hi_q;
    logic             locked_q;
    logic             overrun_q;

    logic [CNT_W:0]   len_d;
    logic [CNT_W-1:0] cnt_a_d;
    logic [CNT_W-1:0] cnt_b_d;
    logic [CNT_W:0]   sum_full_d;
    logic [CNT_W-1:0] sum_d;
    logic             slot_end_d;
    logic             bit_d;
    logic             tie_d;
    logic [ERR_W-1:0] err_d;

    sync_edge u_sync (
        .clk    (clk),
        .rst    (sclear),
        .d_i    (din),
        .sync_o (din_s),
        .rise_o (rise)
    );

    // Integrator next values include the current sample so the decision
    // at the last slot position sees the whole slot.
    always_comb begin
        len_d      = slot_len(N);
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        if (din_s) begin
            if (pos_q < h_q) begin
                if (cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
            end else begin
                if (cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
            end
        end
        sum_full_d = {1'b0, cnt_a_d} + {1'b0, cnt_b_d};
        sum_d      = sum_full_d[CNT_W] ? '1 : sum_full_d[CNT_W-1:0];
        slot_end_d = (pos_q == l_q - 1'b1);
        bit_d      = (cnt_b_d > cnt_a_d);
        tie_d      = (cnt_b_d == cnt_a_d);
        err_d      = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge sclear) begin
        if (sclear) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            l_q       <= '0;
            h_q       <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            bit_q     <= 1'b0;
            era_q     <= 1'b0;
            hi_q      <= '0;
            locked_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!en) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (valid_q && out_ready) valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= ST_HUNT;
                ST_HUNT: begin
                    // The rise cycle is slot position 0 and its sample is high.
                    if (rise) begin
                        state_q  <= ST_TRACK;
                        locked_q <= 1'b1;
                        pos_q    <= {{CNT_W{1'b0}}, 1'b1};
                        cnt_a_q  <= CNT_W'(1);
                        cnt_b_q  <= '0;
                        l_q      <= len_d;
                        h_q      <= len_d >> 1;
                        err_q    <= '0;
                    end
                end
                ST_TRACK: begin
                    if (slot_end_d) begin
                        pos_q   <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        l_q     <= len_d;
                        h_q     <= len_d >> 1;
                        if (!valid_q || out_ready) begin
                            valid_q <= 1'b1;
                            bit_q   <= bit_d;
                            era_q   <= tie_d;
                            hi_q    <= sum_d;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        if (!tie_d) begin
                            err_q <= '0;
                        end else if (err_d >= c_LOSS_MAX) begin
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                            err_q    <= '0;
                        end else begin
                            err_q <= err_d;
                        end
                    end else begin
                        pos_q   <= pos_q + 1'b1;
                        cnt_a_q <= cnt_a_d;
                        cnt_b_q <= cnt_b_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign bit_out   = bit_q;
    assign erasure   = era_q;
    assign hi_cnt    = hi_q;
    assign locked    = locked_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vppm_slot_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_vppm_slot_demod
// Description : Randomised bench for vppm_slot_demod against a slot-level
//               reference model of the received waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vppm_slot_demod;

    localparam int LOSS = 4;
    localparam int MAXC = 400;
    localparam int NSEG = 10;

    logic        clk = 1'b0;
    logic        sclear;
    logic        en;
    logic        din;
    logic [25:0] n_in;
    logic        out_ready;
    logic        out_valid;
    logic        bit_out;
    logic        erasure;
    logic [25:0] hi_cnt;
    logic        locked;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // Per-edge stimulus and expectations; index k is the k-th clock edge of a segment.
    int d    [0:MAXC];
    int nv   [0:MAXC];
    bit rdy  [0:MAXC];
    bit lk   [0:MAXC];
    bit rv   [0:MAXC];
    bit rbit [0:MAXC];
    bit rer  [0:MAXC];
    int rhi  [0:MAXC];

    vppm_slot_demod #(.LOSS_SLOTS(LOSS)) dut (
        .clk       (clk),
        .sclear    (sclear),
        .en        (en),
        .din       (din),
        .N         (n_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bit_out   (bit_out),
        .erasure   (erasure),
        .hi_cnt    (hi_cnt),
        .locked    (locked),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Synchronised sample seen by the demodulator at edge j.
    function automatic int samp(input int j);
        return (j >= 2) ? d[j-2] : 0;
    endfunction

    task automatic gen(input int seg, input int ncyc);
        int nb, len, t, w, kind, run, idx, off;
        for (int k = 0; k <= MAXC; k++) begin
            d[k]   = 0;
            rdy[k] = (seg == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        nb = (seg == 0) ? 8 : $urandom_range(0, 12);
        for (int k = 0; k <= MAXC; k++) nv[k] = nb;
        if (seg > 1 && $urandom_range(0, 1) == 1) begin
            int c  = $urandom_range(20, ncyc / 2);
            int n2 = $urandom_range(0, 12);
            for (int k = c; k <= MAXC; k++) nv[k] = n2;
        end
        if (seg > 0) begin
            int s = $urandom_range(10, ncyc - 60);
            for (int k = s; k <= s + 3 * (nb + 2) && k <= MAXC; k++) rdy[k] = 1'b0;
        end
        len = nb + 2;
        t   = $urandom_range(3, 8);
        idx = 0;
        off = (seg == 0) ? 1 : 0;
        while (t + len < ncyc) begin
            if (seg == 0) kind = (idx % 4 == 1 || idx % 4 == 2) ? 2 : 0;
            else          kind = (idx == 0) ? 0 : $urandom_range(0, 5);
            w = (seg == 0) ? 3 : $urandom_range(1, len / 2);
            if (kind <= 1) begin
                for (int p = 0; p < w; p++) d[t + p] = 1;
                t += len;
            end else if (kind <= 3) begin
                for (int p = len - w - off; p < len - off; p++) d[t + p] = 1;
                t += len;
            end else if (kind == 4) begin
                run = $urandom_range(1, 6);
                t += run * len;
            end else begin
                for (int p = 0; p < len; p++) d[t + p] = $urandom_range(0, 1);
                t += len;
            end
            idx++;
        end
        for (int k = ncyc; k <= MAXC; k++) d[k] = 0;
    endtask

    // Slot-level model: find the locking rise, then cut the sample stream into
    // slots of N+2 samples and compare the light in each half.
    task automatic build_model(input int ncyc);
        int t, st, len, hh, a, b, erc, e;
        bit trk;
        for (int k = 0; k <= MAXC; k++) begin
            rv[k] = 1'b0; lk[k] = 1'b0; rbit[k] = 1'b0; rer[k] = 1'b0; rhi[k] = 0;
        end
        t = 2; trk = 1'b0; erc = 0; st = 0; len = 2;
        while (1) begin
            if (!trk) begin
                while (t <= ncyc && !(samp(t) != 0 && samp(t - 1) == 0)) t++;
                if (t > ncyc) break;
                st  = t;
                len = nv[t] + 2;
                trk = 1'b1;
                for (int k = st; k <= MAXC; k++) lk[k] = 1'b1;
            end
            hh = len / 2;
            e  = st + len - 1;
            if (e > ncyc) break;
            a = 0; b = 0;
            for (int p = 0; p < len; p++)
                if (samp(st + p) != 0) begin
                    if (p < hh) a++;
                    else        b++;
                end
            rv[e] = 1'b1; rbit[e] = (b > a); rer[e] = (a == b); rhi[e] = a + b;
            erc = (a == b) ? erc + 1 : 0;
            if (erc >= LOSS) begin
                trk = 1'b0; erc = 0; t = e + 1;
                for (int k = e; k <= MAXC; k++) lk[k] = 1'b0;
            end else begin
                st  = e + 1;
                len = nv[e] + 2;
            end
        end
    endtask

    task automatic run_seg(input int seg, input int ncyc, input bit en_drop);
        int  run;
        bit  v, ov, vb, ve;
        int  vh;
        gen(seg, ncyc);
        build_model(ncyc);
        // End a few cycles after the last decision while holding the result.
        run = ncyc;
        for (int k = ncyc - 5; k >= 1; k--)
            if (rv[k]) begin
                run = k + 4;
                for (int j = k + 1; j <= k + 4; j++) rdy[j] = 1'b0;
                break;
            end

        sclear = 1'b1; en = 1'b0; din = 1'b0; out_ready = 1'b0; n_in = 26'(nv[1]);
        @(posedge clk); #1;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_hi", {6'd0, hi_cnt}, 0);
        check("rst_bit", {30'd0, bit_out, erasure}, 0);

        sclear = 1'b0; en = 1'b1;
        din = (d[1] != 0); n_in = 26'(nv[1]); out_ready = rdy[1];
        v = 1'b0; ov = 1'b0; vb = 1'b0; ve = 1'b0; vh = 0;
        for (int k = 1; k <= run; k++) begin
            @(posedge clk); #1;
            if (rv[k]) begin
                if (!v || rdy[k]) begin
                    v = 1'b1; vb = rbit[k]; ve = rer[k]; vh = rhi[k];
                end else begin
                    ov = 1'b1;
                end
            end else if (v && rdy[k]) begin
                v = 1'b0;
            end
            check("valid", {31'd0, out_valid}, {31'd0, v});
            check("locked", {31'd0, locked}, {31'd0, lk[k]});
            check("overrun", {31'd0, overrun}, {31'd0, ov});
            if (v) begin
                check("bit", {31'd0, bit_out}, {31'd0, vb});
                check("erasure", {31'd0, erasure}, {31'd0, ve});
                check("hi_cnt", {6'd0, hi_cnt}, vh);
            end
            if (k < run) begin
                din = (d[k + 1] != 0); n_in = 26'(nv[k + 1]); out_ready = rdy[k + 1];
            end
        end

        if (en_drop) begin
            en = 1'b0;
            @(posedge clk); #1;
            check("endrop_valid", {31'd0, out_valid}, 0);
            check("endrop_locked", {31'd0, locked}, 0);
            check("endrop_overrun", {31'd0, overrun}, 0);
        end else begin
            sclear = 1'b1;
            #1;
            check("sclr_valid", {31'd0, out_valid}, 0);
            check("sclr_locked", {31'd0, locked}, 0);
            check("sclr_overrun", {31'd0, overrun}, 0);
            check("sclr_hi", {6'd0, hi_cnt}, 0);
            check("sclr_bit", {30'd0, bit_out, erasure}, 0);
        end
    endtask

    initial begin
        sclear = 1'b1; en = 1'b0; din = 1'b0; out_ready = 1'b0; n_in = 26'd8;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < NSEG; s++)
            run_seg(s, (s == 0) ? 100 : $urandom_range(150, 300), (s % 3 == 2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
